// File: rtl/serial_bit_tx_pkg.sv
// rtl/serial_bit_tx_pkg.sv - shared types and constants for serial_bit_tx
// Purpose: FSM state encoding and default word width for the serial transmitter.
// Contents: state_e (ST_IDLE, ST_SHIFT, ST_PARITY), DEFAULT_NBITS.
// ST_PARITY is only reachable when SERIAL_BIT_TX_PARITY_EN is defined.
package serial_bit_tx_pkg;

  localparam int DEFAULT_NBITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

endpackage

// File: rtl/serial_bit_tx_if.sv
// rtl/serial_bit_tx_if.sv - word handshake and serial stream bundle for serial_bit_tx
// Purpose: groups the parallel-word val/rdy handshake and the (en, d, last) serial stream.
// Ports (signals):
//   in_val   source -> tx   word on in_msg is valid
//   in_rdy   tx -> source   transmitter accepts a word this cycle
//   in_msg   source -> tx   NBITS-wide word to serialize
//   out_en   tx -> sink     out_d is a live bit this cycle
//   out_d    tx -> sink     serial data bit, LSB first
//   out_last tx -> sink     final beat of the current word
// Modports: master = word source / stream sink side, slave = transmitter side.
interface serial_bit_tx_if
  import serial_bit_tx_pkg::*;
#(
  parameter int NBITS = DEFAULT_NBITS
);

  logic             in_val;
  logic             in_rdy;
  logic [NBITS-1:0] in_msg;
  logic             out_en;
  logic             out_d;
  logic             out_last;

  modport master (
    output in_val,
    output in_msg,
    input  in_rdy,
    input  out_en,
    input  out_d,
    input  out_last
  );

  modport slave (
    input  in_val,
    input  in_msg,
    output in_rdy,
    output out_en,
    output out_d,
    output out_last
  );

endinterface

// File: rtl/serial_bit_tx_shreg.sv
// rtl/serial_bit_tx_shreg.sv - NBITS load / shift-right register
// Purpose: holds the word being serialized; bit 0 is the current serial bit.
// Ports:
//   clk       input        rising-edge clock
//   reset     input        synchronous active-high reset (clears to 0)
//   load      input        capture load_data (wins over shift)
//   shift     input        shift right by one, zero fill
//   load_data input NBITS  word to capture
//   bit0      output       current LSB
module serial_bit_tx_shreg
  import serial_bit_tx_pkg::*;
#(
  parameter int NBITS = DEFAULT_NBITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [NBITS-1:0] load_data,
  output logic             bit0
);

  logic [NBITS-1:0] data_q;
  logic [NBITS-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_data;
    end else if (shift) begin
      data_d = {1'b0, data_q[NBITS-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign bit0 = data_q[0];

endmodule

// File: rtl/serial_bit_tx.sv
// rtl/serial_bit_tx.sv - parallel-to-serial transmitter, LSB first, (en, d, last) beats
// Purpose: accepts an NBITS word over val/rdy and emits one bit per cycle with no gaps
//   between back-to-back words. Optional macro SERIAL_BIT_TX_PARITY_EN appends an
//   even-parity beat after the data bits.
// Ports:
//   clk    input  rising-edge clock
//   reset  input  synchronous active-high reset
//   bus    serial_bit_tx_if.slave  in_val/in_rdy/in_msg handshake, out_en/out_d/out_last stream
module serial_bit_tx
  import serial_bit_tx_pkg::*;
#(
  parameter int NBITS = DEFAULT_NBITS
) (
  input  logic           clk,
  input  logic           reset,
  serial_bit_tx_if.slave bus
);

  localparam int             CW       = $clog2(NBITS);
  localparam logic [CW-1:0]  CNT_LAST = CW'(NBITS - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          shreg_bit0;
  logic          last_bit;
  logic          xfer;
  logic          rdy, en, d, last;
`ifdef SERIAL_BIT_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  assign last_bit = (cnt_q == CNT_LAST);
  // rdy depends on state/counter only, so xfer has no combinational loop via in_val
  assign xfer     = bus.in_val && rdy;

  serial_bit_tx_shreg #(.NBITS(NBITS)) u_shreg (
    .clk       (clk),
    .reset     (reset),
    .load      (xfer),
    .shift     (state_q == ST_SHIFT),
    .load_data (bus.in_msg),
    .bit0      (shreg_bit0)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
`ifdef SERIAL_BIT_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_BIT_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_BIT_TX_PARITY_EN
    parity_d = xfer ? ^bus.in_msg : parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (!last_bit) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
`ifdef SERIAL_BIT_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          // a word accepted on the final beat continues straight into its bit 0
          state_d = xfer ? ST_SHIFT : ST_IDLE;
          cnt_d   = '0;
`endif
        end
      end
`ifdef SERIAL_BIT_TX_PARITY_EN
      ST_PARITY: begin
        state_d = xfer ? ST_SHIFT : ST_IDLE;
        cnt_d   = '0;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    rdy  = 1'b1;
    en   = 1'b0;
    d    = 1'b0;
    last = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        en = 1'b1;
        d  = shreg_bit0;
`ifdef SERIAL_BIT_TX_PARITY_EN
        last = 1'b0;
`else
        last = last_bit;
`endif
        rdy = last;
      end
`ifdef SERIAL_BIT_TX_PARITY_EN
      ST_PARITY: begin
        en   = 1'b1;
        d    = parity_q;
        last = 1'b1;
        rdy  = 1'b1;
      end
`endif
      default: begin
        rdy  = 1'b1;
        en   = 1'b0;
        d    = 1'b0;
        last = 1'b0;
      end
    endcase
  end

  assign bus.in_rdy   = rdy;
  assign bus.out_en   = en;
  assign bus.out_d    = d;
  assign bus.out_last = last;

endmodule

// File: tb/tb_serial_bit_tx.sv
// tb/tb_serial_bit_tx.sv - self-checking bench for serial_bit_tx (honours SERIAL_BIT_TX_PARITY_EN)
module tb_serial_bit_tx;

  localparam int NBITS = 8;
`ifdef SERIAL_BIT_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int BEATS = NBITS + PAR;

  logic clk = 1'b0;
  logic reset = 1'b1;

  serial_bit_tx_if #(.NBITS(NBITS)) bus ();

  serial_bit_tx #(.NBITS(NBITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: a queue of pending beats. A word accepted at an edge becomes its beat list;
  // the transmitter is ready when nothing is pending or the pending beat is the last.
  typedef struct packed {
    logic d;
    logic last;
  } beat_t;

  beat_t mq[$];
  bit    model_active = 0;
  bit    m_rdy;
  int    cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      mq.delete();
      model_active = 1;
    end else begin
      m_rdy = (mq.size() == 0) || mq[0].last;
      if (mq.size() > 0) void'(mq.pop_front());
      if (bus.in_val && m_rdy) begin
        for (int i = 0; i < NBITS; i++) begin
          mq.push_back('{d: bus.in_msg[i], last: (PAR == 0) && (i == NBITS - 1)});
        end
        if (PAR != 0) mq.push_back('{d: ^bus.in_msg, last: 1'b1});
      end
    end
  end

  logic cap_d[$];
  logic cap_last[$];
  logic cap_rdy[$];
  int   cap_cyc[$];
  logic [3:0] exp_vec;

  always @(negedge clk) begin
    if (model_active) begin
      if (mq.size() == 0) exp_vec = 4'b1000;
      else exp_vec = {mq[0].last, 1'b1, mq[0].d, mq[0].last};
      check("cycle {rdy,en,d,last}", {28'd0, bus.in_rdy, bus.out_en, bus.out_d, bus.out_last},
            {28'd0, exp_vec});
      if (bus.out_en) begin
        cap_d.push_back(bus.out_d);
        cap_last.push_back(bus.out_last);
        cap_rdy.push_back(bus.in_rdy);
        cap_cyc.push_back(cyc);
      end
    end
  end

  task automatic clear_cap();
    cap_d.delete();
    cap_last.delete();
    cap_rdy.delete();
    cap_cyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a word and hold it until the handshake edge; bounded wait.
  task automatic send(input logic [NBITS-1:0] w, input bit hold_after);
    bit r;
    bit done;
    done = 0;
    bus.in_val = 1'b1;
    bus.in_msg = w;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      r = bus.in_rdy;
      @(posedge clk);
      #1;
      if (r) done = 1;
    end
    check("send handshake", {31'd0, done}, 32'd1);
    if (!hold_after) bus.in_val = 1'b0;
  endtask

  // Beat i of the captured stream is compared against bit i of the literals.
  task automatic check_beats(input string name, input int n, input logic [31:0] dseq,
                             input logic [31:0] lseq);
    check({name, " beat count"}, cap_d.size(), n);
    for (int i = 0; i < n && i < cap_d.size(); i++) begin
      check({name, " d"}, {31'd0, cap_d[i]}, {31'd0, dseq[i]});
      check({name, " last"}, {31'd0, cap_last[i]}, {31'd0, lseq[i]});
      check({name, " rdy"}, {31'd0, cap_rdy[i]}, {31'd0, lseq[i]});
    end
    if (cap_cyc.size() > 0)
      check({name, " contiguous"}, cap_cyc[cap_cyc.size()-1] - cap_cyc[0], n - 1);
  endtask

  initial begin
    bus.in_val = 1'b0;
    bus.in_msg = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle in_rdy", {31'd0, bus.in_rdy}, 32'd1);
      check("idle out_en", {31'd0, bus.out_en}, 32'd0);
      check("idle out_d", {31'd0, bus.out_d}, 32'd0);
    end
    idle(1);

    clear_cap();
    send(8'hA5, 0);
    idle(BEATS + 2);
`ifndef SERIAL_BIT_TX_PARITY_EN
    check_beats("a5", 8, 32'h0000_00A5, 32'h0000_0080);
`else
    check_beats("a5", 9, 32'h0000_00A5, 32'h0000_0100);
`endif

    clear_cap();
    send(8'h0F, 1);
    send(8'hF0, 0);
    idle(BEATS + 2);
`ifndef SERIAL_BIT_TX_PARITY_EN
    check_beats("b2b 0f f0", 16, 32'h0000_F00F, 32'h0000_8080);
`else
    check_beats("b2b 0f f0", 18, 32'h0001_E00F, 32'h0002_0100);
`endif

    clear_cap();
    send(8'hFF, 0);
    idle(1);
    idle(1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    @(negedge clk);
    check("post-reset out_en", {31'd0, bus.out_en}, 32'd0);
    check("post-reset in_rdy", {31'd0, bus.in_rdy}, 32'd1);
    check("beats before reset", cap_d.size(), 3);
    idle(1);
    clear_cap();
    send(8'h01, 0);
    idle(BEATS + 2);
`ifndef SERIAL_BIT_TX_PARITY_EN
    check_beats("after reset 01", 8, 32'h0000_0001, 32'h0000_0080);
`else
    check_beats("after reset 01", 9, 32'h0000_0101, 32'h0000_0100);
`endif

    clear_cap();
    send(8'hFF, 1);
    send(8'h00, 0);
    idle(BEATS + 2);
`ifndef SERIAL_BIT_TX_PARITY_EN
    check_beats("ff then 00", 16, 32'h0000_00FF, 32'h0000_8080);
`else
    check_beats("ff then 00", 18, 32'h0000_00FF, 32'h0002_0100);
`endif

`ifdef SERIAL_BIT_TX_PARITY_EN
    clear_cap();
    send(8'h07, 0);
    idle(BEATS + 2);
    check_beats("parity 07", 9, 32'h0000_0107, 32'h0000_0100);
`endif

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
